// File: rtl/irq_prio_sched.sv
// Three-bus priority interrupt scheduler: pending/mask capture, ARB/OFFER/SERVICE handshake, ack timeout.
// Define IRQ_PRIO_SCHED_ROTATE_EN for rotating bus priority (default: fixed A > B > C).
module irq_prio_sched #(
    parameter int NCH         = 9,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req_a,
    input  logic [NCH-1:0] req_b,
    input  logic [NCH-1:0] req_c,
    input  logic           mask_wr,
    input  logic [3*NCH-1:0] mask_din,
    input  logic           ack,
    input  logic           eoi,
    output logic           irq,
    output logic [2:0]     grant_bus,
    output logic [3:0]     grant_chan,
    output logic           busy,
    output logic           timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARB     = 2'd1;
    localparam logic [1:0] S_OFFER   = 2'd2;
    localparam logic [1:0] S_SERVICE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [3*NCH-1:0]     pending_q, pending_d;
    logic [3*NCH-1:0]     mask_q, mask_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           gbus_q, gbus_d;
    logic [3:0]           gchan_q, gchan_d;
    logic                 timeout_q, timeout_d;
    logic [3*NCH-1:0]     clr;
    logic [1:0]           hi_bus;
    logic [1:0]           win_bus;
    logic [3:0]           win_chan;
    logic                 win_found;

`ifdef IRQ_PRIO_SCHED_ROTATE_EN
    logic [1:0] rot_q, rot_d;
    assign hi_bus = rot_q;
`else
    assign hi_bus = 2'd0;
`endif

    // Scan buses starting at the highest-priority one; lowest channel wins inside a bus.
    always_comb begin
        win_found = 1'b0;
        win_bus   = 2'd0;
        win_chan  = 4'd0;
        for (int k = 0; k < 3; k++) begin
            int b;
            b = int'(hi_bus) + k;
            if (b > 2) b = b - 3;
            if (!win_found && |pending_q[b*NCH +: NCH]) begin
                win_found = 1'b1;
                win_bus   = 2'(b);
                for (int c = NCH - 1; c >= 0; c--) begin
                    if (pending_q[b*NCH + c]) win_chan = 4'(c);
                end
            end
        end
    end

    always_comb begin
        clr = '0;
        for (int b = 0; b < 3; b++) begin
            if (gbus_q[b]) clr[b*NCH +: NCH] = NCH'(1) << gchan_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gbus_d    = gbus_q;
        gchan_d   = gchan_q;
        timeout_d = 1'b0;
        mask_d    = mask_wr ? mask_din : mask_q;
`ifdef IRQ_PRIO_SCHED_ROTATE_EN
        rot_d     = rot_q;
`endif
        // Set beats clear so a request landing on the eoi cycle is not lost.
        pending_d = (pending_q & ~((state_q == S_SERVICE && eoi) ? clr : '0))
                  | ({req_c, req_b, req_a} & ~mask_q);
        case (state_q)
            S_IDLE: begin
                if (|pending_q) state_d = S_ARB;
            end
            S_ARB: begin
                if (win_found) begin
                    gbus_d  = 3'b001 << win_bus;
                    gchan_d = win_chan;
                    cnt_d   = 8'd0;
                    state_d = S_OFFER;
`ifdef IRQ_PRIO_SCHED_ROTATE_EN
                    rot_d   = (win_bus == 2'd2) ? 2'd0 : win_bus + 2'd1;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OFFER: begin
                if (ack) begin
                    state_d = S_SERVICE;
                end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                    gbus_d    = 3'b000;
                    gchan_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SERVICE: begin
                if (eoi) begin
                    state_d = S_IDLE;
                    gbus_d  = 3'b000;
                    gchan_d = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            cnt_q     <= 8'd0;
            gbus_q    <= 3'b000;
            gchan_q   <= 4'd0;
            timeout_q <= 1'b0;
`ifdef IRQ_PRIO_SCHED_ROTATE_EN
            rot_q     <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            gbus_q    <= gbus_d;
            gchan_q   <= gchan_d;
            timeout_q <= timeout_d;
`ifdef IRQ_PRIO_SCHED_ROTATE_EN
            rot_q     <= rot_d;
`endif
        end
    end

    assign irq        = (state_q == S_OFFER);
    assign busy       = (state_q != S_IDLE);
    assign grant_bus  = gbus_q;
    assign grant_chan = gchan_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_irq_prio_sched.sv
// Directed bench for irq_prio_sched in its default (fixed-priority) build.
module tb_irq_prio_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  req_a = '0, req_b = '0, req_c = '0;
    logic        mask_wr = 1'b0;
    logic [26:0] mask_din = '0;
    logic        ack = 1'b0, eoi = 1'b0;
    logic        irq, busy, timeout;
    logic [2:0]  grant_bus;
    logic [3:0]  grant_chan;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    irq_prio_sched #(.NCH(9), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .mask_wr(mask_wr), .mask_din(mask_din),
        .ack(ack), .eoi(eoi),
        .irq(irq), .grant_bus(grant_bus), .grant_chan(grant_chan),
        .busy(busy), .timeout(timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed/expected packed as {irq, grant_bus, grant_chan, busy, timeout}.
    task automatic expect_st(input string tag, input logic e_irq, input logic [2:0] e_bus,
                             input logic [3:0] e_chan, input logic e_busy, input logic e_to);
        logic [9:0] obs, exp;
        obs = {irq, grant_bus, grant_chan, busy, timeout};
        exp = {e_irq, e_bus, e_chan, e_busy, e_to};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed irq/bus/chan/busy/to=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic serve();
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    initial begin
        tick(); tick();
        expect_st("reset", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Single request: pending, ARB, OFFER on successive edges.
        req_a = 9'h001; tick(); req_a = 9'h000;
        expect_st("lat_pend", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);
        tick();
        expect_st("lat_arb", 1'b0, 3'b000, 4'd0, 1'b1, 1'b0);
        tick();
        expect_st("lat_offer", 1'b1, 3'b001, 4'd0, 1'b1, 1'b0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        expect_st("eoi_in_offer_ignored", 1'b1, 3'b001, 4'd0, 1'b1, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        expect_st("service", 1'b0, 3'b001, 4'd0, 1'b1, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        expect_st("ack_in_service_ignored", 1'b0, 3'b001, 4'd0, 1'b1, 1'b0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        expect_st("eoi_done", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);
        tick();
        expect_st("idle_after_eoi", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);

        // Three buses at once: A/ch8, then B/ch0, then C/ch0.
        req_a = 9'h100; req_b = 9'h001; req_c = 9'h001; tick();
        req_a = 9'h000; req_b = 9'h000; req_c = 9'h000;
        tick(); tick();
        expect_st("prio_first_a8", 1'b1, 3'b001, 4'd8, 1'b1, 1'b0);
        serve(); tick(); tick();
        expect_st("prio_second_b0", 1'b1, 3'b010, 4'd0, 1'b1, 1'b0);
        serve(); tick(); tick();
        expect_st("prio_third_c0", 1'b1, 3'b100, 4'd0, 1'b1, 1'b0);
        serve(); tick();
        expect_st("prio_all_served", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);

        // Masked request never becomes pending; unmasking lets the held request through.
        mask_wr = 1'b1; mask_din = 27'h0000008; tick(); mask_wr = 1'b0;
        req_a = 9'h008;
        tick(); tick(); tick(); tick();
        expect_st("masked_no_irq", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);
        mask_wr = 1'b1; mask_din = 27'h0; tick(); mask_wr = 1'b0;
        expect_st("unmask_edge", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);
        tick();
        expect_st("unmask_pend", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);
        tick();
        expect_st("unmask_arb", 1'b0, 3'b000, 4'd0, 1'b1, 1'b0);
        tick();
        expect_st("unmask_offer_a3", 1'b1, 3'b001, 4'd3, 1'b1, 1'b0);
        req_a = 9'h000;
        mask_wr = 1'b1; mask_din = 27'h0000008; tick(); mask_wr = 1'b0;
        expect_st("mask_no_revoke", 1'b1, 3'b001, 4'd3, 1'b1, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        mask_wr = 1'b1; mask_din = 27'h0; tick(); mask_wr = 1'b0;
        expect_st("mask_service_held", 1'b0, 3'b001, 4'd3, 1'b1, 1'b0);
        // eoi and a fresh set of the same bit together: the bit stays pending.
        eoi = 1'b1; req_a = 9'h008; tick(); eoi = 1'b0; req_a = 9'h000;
        expect_st("set_wins_eoi", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);
        tick();
        expect_st("set_wins_arb", 1'b0, 3'b000, 4'd0, 1'b1, 1'b0);
        tick();
        expect_st("set_wins_reoffer", 1'b1, 3'b001, 4'd3, 1'b1, 1'b0);
        serve(); tick();
        expect_st("set_wins_drained", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);

        // Ack timeout: 15 OFFER cycles, pulse, then re-offer of the retained bit.
        req_b = 9'h010; tick(); req_b = 9'h000;
        tick(); tick();
        expect_st("to_offer_b4", 1'b1, 3'b010, 4'd4, 1'b1, 1'b0);
        repeat (14) tick();
        expect_st("to_before_expiry", 1'b1, 3'b010, 4'd4, 1'b1, 1'b0);
        tick();
        expect_st("to_pulse", 1'b0, 3'b000, 4'd0, 1'b0, 1'b1);
        tick();
        expect_st("to_pulse_end_arb", 1'b0, 3'b000, 4'd0, 1'b1, 1'b0);
        tick();
        expect_st("to_reoffer_b4", 1'b1, 3'b010, 4'd4, 1'b1, 1'b0);
        repeat (14) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        expect_st("ack_beats_timeout", 1'b0, 3'b010, 4'd4, 1'b1, 1'b0);
        tick();
        expect_st("service_holds", 1'b0, 3'b010, 4'd4, 1'b1, 1'b0);

        // Reset in SERVICE clears everything immediately; nothing comes back.
        rst = 1'b1; #1;
        expect_st("rst_async_service", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);
        tick(); rst = 1'b0;
        tick(); tick(); tick();
        expect_st("rst_no_regrant", 1'b0, 3'b000, 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
